// File: rtl/op_eval_pkg.sv
// Shared opcode, state and helper definitions for the operator-evaluation unit.
package op_eval_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LOGIC = 3'b010;
  localparam logic [2:0] OP_EQ    = 3'b011;
  localparam logic [2:0] OP_SLL   = 3'b100;
  localparam logic [2:0] OP_SRL   = 3'b101;
  localparam logic [2:0] OP_SRA   = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/op_eval_shifter.sv
// Bit-serial shifter: working register plus down-counter, one position per step.
module op_eval_shifter
  import op_eval_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               dir_left,
  input  logic               arith,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [SHAMT_W-1:0] load_cnt,
  output logic [WIDTH-1:0]   val,
  output logic               last_out,
  output logic               done
);

  logic [WIDTH-1:0]   val_q, val_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               out_q, out_d;

  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (load) begin
      val_d = load_val;
      cnt_d = load_cnt;
      out_d = 1'b0;
    end else if (step) begin
      if (dir_left) begin
        val_d = {val_q[WIDTH-2:0], 1'b0};
        out_d = val_q[WIDTH-1];
      end else begin
        val_d = {arith & val_q[WIDTH-1], val_q[WIDTH-1:1]};
        out_d = val_q[0];
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign val      = val_q;
  assign last_out = out_q;
  // Asserted during the final step so the controller leaves SHIFT on that edge.
  assign done     = (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/op_eval_unit.sv
// Iterative operator evaluator: one request in flight, valid/ready on both sides.
module op_eval_unit
  import op_eval_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [SHAMT_W-1:0] req_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_flag,
  output logic               rsp_err
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;

  logic             accept;
  logic             shf_load, shf_step, shf_done, shf_out;
  logic [WIDTH-1:0] shf_val;
  logic [WIDTH:0]   sum, diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)
                  state_d = (is_shift(req_op) && (req_shamt != '0)) ? ST_SHIFT : ST_RESP;
      ST_SHIFT: if (shf_done) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    accept    = req_valid && req_ready;
    shf_load  = accept && is_shift(req_op);
    shf_step  = (state_q == ST_SHIFT);
  end

  always_comb begin
    op_d = accept ? req_op : op_q;
    a_d  = accept ? req_a  : a_q;
    b_d  = accept ? req_b  : b_q;
  end

  // Zero shifts also go through the shifter: it loads a and clears the flag.
  op_eval_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (shf_load),
    .step     (shf_step),
    .dir_left (op_q == OP_SLL),
    .arith    (op_q == OP_SRA),
    .load_val (req_a),
    .load_cnt (req_shamt),
    .val      (shf_val),
    .last_out (shf_out),
    .done     (shf_done)
  );

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  // Results derive from registered operands only, so they hold under backpressure.
  always_comb begin
    rsp_result = '0;
    rsp_flag   = 1'b0;
    rsp_err    = 1'b0;
    case (op_q)
      OP_ADD: begin
        rsp_result = sum[WIDTH-1:0];
        rsp_flag   = sum[WIDTH];
      end
      OP_SUB: begin
        rsp_result = diff[WIDTH-1:0];
        rsp_flag   = diff[WIDTH];
      end
      OP_LOGIC: begin
        rsp_flag   = (a_q != '0) || (b_q == '0);
        rsp_result = {{(WIDTH-1){1'b0}}, rsp_flag};
      end
      OP_EQ: begin
        rsp_flag   = (a_q == b_q);
        rsp_result = {{(WIDTH-1){1'b0}}, rsp_flag};
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        rsp_result = shf_val;
        rsp_flag   = shf_out;
      end
      default: rsp_err = 1'b1;
    endcase
  end

endmodule
